// File: rtl/led_pattern_seq.sv
// LED pattern source: tick divider, debounced mode button, 4-bit pattern stepper driving active-low LEDs.
// Optional `fast` input (quarter tick period) is compiled in when LED_SPEED_EN is defined.
module led_pattern_seq #(
  parameter int unsigned TICK_DIV   = 2500000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
`ifdef LED_SPEED_EN
  input  logic       fast,
`endif
  input  logic       key_n,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  typedef enum logic [1:0] {
    SHIFT_L = 2'd0,
    SHIFT_R = 2'd1,
    COUNT   = 2'd2,
    ALT     = 2'd3
  } mode_e;

  localparam logic [31:0] WRAP_SLOW = 32'(TICK_DIV - 1);
`ifdef LED_SPEED_EN
  localparam logic [31:0] WRAP_FAST = 32'((TICK_DIV >> 2) - 1);
`endif
  localparam logic [23:0] DEB_LAST  = 24'(DEB_CYCLES - 1);

  logic [31:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic [31:0] wrap_lim;
  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic        deb_q, deb_d;
  logic [23:0] deb_cnt_q, deb_cnt_d;
  logic        press_q, press_d;
  mode_e       state_q, state_d;
  logic [3:0]  pattern_q, pattern_d;

  // ">=" rather than "==" so raising fast past the short limit wraps on the next cycle.
  always_comb begin
    wrap_lim = WRAP_SLOW;
`ifdef LED_SPEED_EN
    if (fast) wrap_lim = WRAP_FAST;
`endif
    tick_d = (cnt_q >= wrap_lim);
    cnt_d  = tick_d ? 32'd0 : cnt_q + 32'd1;
  end

  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = 24'd0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 24'd1;
      end
    end
    press_d = deb_q & ~deb_d;
  end

  // A press outranks a coincident tick: the seed is loaded and that step is dropped.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    if (press_q) begin
      case (state_q)
        SHIFT_L: begin state_d = SHIFT_R; pattern_d = 4'b1000; end
        SHIFT_R: begin state_d = COUNT;   pattern_d = 4'b0000; end
        COUNT:   begin state_d = ALT;     pattern_d = 4'b0101; end
        ALT:     begin state_d = SHIFT_L; pattern_d = 4'b0001; end
        default: ;
      endcase
    end else if (tick_q) begin
      case (state_q)
        SHIFT_L: pattern_d = {pattern_q[2:0], pattern_q[3]};
        SHIFT_R: pattern_d = {pattern_q[0], pattern_q[3:1]};
        COUNT:   pattern_d = pattern_q + 4'd1;
        ALT:     pattern_d = ~pattern_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 32'd0;
      tick_q    <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      deb_cnt_q <= 24'd0;
      press_q   <= 1'b0;
      state_q   <= SHIFT_L;
      pattern_q <= 4'b0001;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      state_q   <= state_d;
      pattern_q <= pattern_d;
    end
  end

  assign led  = ~pattern_q;
  assign mode = state_q;
  assign tick = tick_q;

endmodule
